// File: rtl/exe_stage_module.sv
// Execute stage of the 5-stage ARM pipeline: forwarding, Val2 generation,
// ALU, branch target adder, NZCV register and the EXE/MEM pipeline register.

module exe_val2_gen (
  input  logic        mem_en,
  input  logic        imm,
  input  logic [11:0] shift_operand,
  input  logic [31:0] rm,
  output logic [31:0] val2
);
  logic [31:0] imm32;
  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;
  logic [31:0] imm_rot;
  logic [31:0] rm_sh;

  assign imm32   = {24'd0, shift_operand[7:0]};
  assign rot_amt = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];

  // A rotate of 0 shifts the left half by 32, which yields 0, so x passes through.
  assign imm_rot = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));

  always_comb begin
    rm_sh = rm;
    case (shift_operand[6:5])
      2'b00: rm_sh = rm << sh_amt;
      2'b01: rm_sh = rm >> sh_amt;
      2'b10: rm_sh = $signed(rm) >>> sh_amt;
      default: rm_sh = (rm >> sh_amt) | (rm << (6'd32 - {1'b0, sh_amt}));
    endcase
  end

  always_comb begin
    val2 = rm_sh;
    if (mem_en)   val2 = {20'd0, shift_operand};
    else if (imm) val2 = imm_rot;
  end
endmodule

module exe_alu (
  input  logic [31:0] op1,
  input  logic [31:0] val2,
  input  logic [3:0]  exe_cmd,
  input  logic        mem_en,
  input  logic        c_in,
  output logic [31:0] res,
  output logic [3:0]  nzcv
);
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]  cmd;
  logic [32:0] sum;
  logic        c;
  logic        v;

  // Loads and stores always compute the address as base + offset.
  assign cmd = mem_en ? CMD_ADD : exe_cmd;

  always_comb begin
    sum = 33'd0;
    res = val2;
    c   = c_in;
    v   = 1'b0;
    case (cmd)
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, op1} + {1'b0, val2} + {32'd0, (cmd == CMD_ADC) & c_in};
        res = sum[31:0];
        c   = sum[32];
        v   = (op1[31] == val2[31]) && (res[31] != op1[31]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, op1} - {1'b0, val2} - {32'd0, (cmd == CMD_SBC) & ~c_in};
        res = sum[31:0];
        c   = ~sum[32];
        v   = (op1[31] != val2[31]) && (res[31] != op1[31]);
      end
      CMD_AND: res = op1 & val2;
      CMD_ORR: res = op1 | val2;
      CMD_EOR: res = op1 ^ val2;
      CMD_MVN: res = ~val2;
      CMD_MOV: res = val2;
      default: res = val2;
    endcase
  end

  assign nzcv = {res[31], (res == 32'd0), c, v};
endmodule

module exe_stage_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        s_in,
  input  logic        imm,
  input  logic [3:0]  exe_cmd,
  input  logic [31:0] val_Rn,
  input  logic [31:0] val_Rm,
  input  logic [11:0] shift_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [31:0] pc_in,
  input  logic [3:0]  dest_in,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] fwd_mem,
  input  logic [31:0] fwd_wb,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] val_Rm_out,
  output logic [3:0]  dest_out,
  output logic [31:0] branch_address,
  output logic [3:0]  status_out,
  output logic        wb_en_hazard,
  output logic [3:0]  dest_hazard
);
  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [3:0]  dest;
  } exe_mem_t;

  logic [31:0] op1;
  logic [31:0] rm;
  logic [31:0] val2;
  logic [31:0] alu_res;
  logic [3:0]  alu_nzcv;
  logic        mem_en;
  exe_mem_t    pipe_d, pipe_q;
  logic [3:0]  status_d, status_q;

  assign mem_en = mem_r_en_in | mem_w_en_in;

  always_comb begin
    op1 = val_Rn;
    case (sel_src1)
      2'b01:   op1 = fwd_mem;
      2'b10:   op1 = fwd_wb;
      default: op1 = val_Rn;
    endcase
  end

  always_comb begin
    rm = val_Rm;
    case (sel_src2)
      2'b01:   rm = fwd_mem;
      2'b10:   rm = fwd_wb;
      default: rm = val_Rm;
    endcase
  end

  exe_val2_gen u_val2 (
    .mem_en        (mem_en),
    .imm           (imm),
    .shift_operand (shift_operand),
    .rm            (rm),
    .val2          (val2)
  );

  exe_alu u_alu (
    .op1     (op1),
    .val2    (val2),
    .exe_cmd (exe_cmd),
    .mem_en  (mem_en),
    .c_in    (status_q[1]),
    .res     (alu_res),
    .nzcv    (alu_nzcv)
  );

  assign branch_address = pc_in + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign wb_en_hazard   = wb_en_in;
  assign dest_hazard    = dest_in;

  always_comb begin
    pipe_d = pipe_q;
    if (!freeze) begin
      pipe_d.wb_en    = wb_en_in;
      pipe_d.mem_r_en = mem_r_en_in;
      pipe_d.mem_w_en = mem_w_en_in;
      pipe_d.alu_res  = alu_res;
      pipe_d.val_rm   = rm;
      pipe_d.dest     = dest_in;
    end
  end

  assign status_d = (s_in && !freeze) ? alu_nzcv : status_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q   <= '0;
      status_q <= 4'd0;
    end else begin
      pipe_q   <= pipe_d;
      status_q <= status_d;
    end
  end

  assign wb_en_out    = pipe_q.wb_en;
  assign mem_r_en_out = pipe_q.mem_r_en;
  assign mem_w_en_out = pipe_q.mem_w_en;
  assign alu_res_out  = pipe_q.alu_res;
  assign val_Rm_out   = pipe_q.val_rm;
  assign dest_out     = pipe_q.dest;
  assign status_out   = status_q;
endmodule

// File: tb/tb_exe_stage_module.sv
// Directed bench for exe_stage_module: expected EXE/MEM contents are queued
// when an instruction is driven and compared after the capturing edge.

module tb_exe_stage_module;
  logic        clk, rst, freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, imm;
  logic [3:0]  exe_cmd, dest_in;
  logic [31:0] val_Rn, val_Rm, pc_in, fwd_mem, fwd_wb;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [1:0]  sel_src1, sel_src2;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, wb_en_hazard;
  logic [31:0] alu_res_out, val_Rm_out, branch_address;
  logic [3:0]  dest_out, status_out, dest_hazard;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic [2:0]  ctrl;  // {wb, mem_r, mem_w}
    logic [3:0]  st;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int checks = 0;
  int failures = 0;

  exe_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .imm(imm), .exe_cmd(exe_cmd),
    .val_Rn(val_Rn), .val_Rm(val_Rm), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .pc_in(pc_in), .dest_in(dest_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .alu_res_out(alu_res_out), .val_Rm_out(val_Rm_out), .dest_out(dest_out),
    .branch_address(branch_address), .status_out(status_out),
    .wb_en_hazard(wb_en_hazard), .dest_hazard(dest_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic [31:0] alu, logic [31:0] rm, logic [3:0] dest,
                              logic [2:0] ctrl, logic [3:0] st);
    exp_t e;
    e.alu = alu; e.rm = rm; e.dest = dest; e.ctrl = ctrl; e.st = st;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(string tag, exp_t e);
    chk({tag, ".alu"},    alu_res_out, e.alu);
    chk({tag, ".rm"},     val_Rm_out, e.rm);
    chk({tag, ".dest"},   {28'd0, dest_out}, {28'd0, e.dest});
    chk({tag, ".ctrl"},   {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, {29'd0, e.ctrl});
    chk({tag, ".status"}, {28'd0, status_out}, {28'd0, e.st});
  endtask

  task automatic step_pop(string tag);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      last = sb.pop_front();
      check_regs(tag, last);
    end
  endtask

  task automatic step_hold(string tag);
    @(posedge clk); #1;
    check_regs(tag, last);
  endtask

  task automatic clear_inputs();
    freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_in = 0; imm = 0;
    exe_cmd = 4'd0; dest_in = 4'd0; val_Rn = 32'd0; val_Rm = 32'd0;
    shift_operand = 12'd0; signed_imm_24 = 24'd0; pc_in = 32'd0;
    sel_src1 = 2'b00; sel_src2 = 2'b00; fwd_mem = 32'd0; fwd_wb = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last = '0;
    check_regs("reset", last);

    // ADD overflow: 0x7FFFFFFF + (Rm=1 LSL #0)
    wb_en_in = 1; s_in = 1; exe_cmd = 4'b0010; val_Rn = 32'h7FFF_FFFF; val_Rm = 32'd1;
    shift_operand = 12'h000; dest_in = 4'd3;
    sb.push_back(mk(32'h8000_0000, 32'd1, 4'd3, 3'b100, 4'b1001));
    step_pop("add_v");

    // SUB to zero, then SBC consuming the freshly written C
    exe_cmd = 4'b0100; imm = 1; shift_operand = 12'h005; val_Rn = 32'd5; val_Rm = 32'h55; dest_in = 4'd4;
    sb.push_back(mk(32'd0, 32'h55, 4'd4, 3'b100, 4'b0110));
    step_pop("sub_z");
    exe_cmd = 4'b0101; s_in = 0; shift_operand = 12'h003; val_Rn = 32'd10; val_Rm = 32'd0; dest_in = 4'd5;
    sb.push_back(mk(32'd7, 32'd0, 4'd5, 3'b100, 4'b0110));
    step_pop("sbc_c1");

    // Immediate rotate 0xFF ror 8
    exe_cmd = 4'b0001; shift_operand = 12'h4FF; dest_in = 4'd6;
    sb.push_back(mk(32'hFF00_0000, 32'd0, 4'd6, 3'b100, 4'b0110));
    step_pop("mov_rot");

    // Store with both operands forwarded; exe_cmd ignored for memory ops
    wb_en_in = 0; mem_w_en_in = 1; imm = 0; exe_cmd = 4'b0100;
    sel_src1 = 2'b01; fwd_mem = 32'h100; val_Rn = 32'hDEAD;
    sel_src2 = 2'b10; fwd_wb = 32'hABCD; val_Rm = 32'h1111;
    shift_operand = 12'h004; dest_in = 4'd7;
    sb.push_back(mk(32'h104, 32'hABCD, 4'd7, 3'b001, 4'b0110));
    step_pop("store_fwd");

    // Load with select 11 meaning register file
    mem_w_en_in = 0; mem_r_en_in = 1; wb_en_in = 1; sel_src1 = 2'b11; sel_src2 = 2'b11;
    val_Rn = 32'h200; val_Rm = 32'h22; shift_operand = 12'hFFF; dest_in = 4'd8;
    sb.push_back(mk(32'h11FF, 32'h22, 4'd8, 3'b110, 4'b0110));
    step_pop("load_sel3");

    // Frozen for three edges while inputs change and s_in is high
    freeze = 1; mem_r_en_in = 0; s_in = 1; sel_src1 = 2'b00; sel_src2 = 2'b00;
    exe_cmd = 4'b0010; val_Rn = 32'h8000_0000; val_Rm = 32'h8000_0000; dest_in = 4'd2;
    step_hold("freeze1");
    val_Rn = 32'h1234;
    step_hold("freeze2");
    exe_cmd = 4'b1000; val_Rn = 32'hF0F0; val_Rm = 32'hFF00; shift_operand = 12'h220; dest_in = 4'd9;
    step_hold("freeze3");
    freeze = 0;
    sb.push_back(mk(32'hFF00, 32'hFF00, 4'd9, 3'b100, 4'b0010));
    step_pop("unfreeze_eor");

    // ASR keeps the sign; MOV leaves C alone
    exe_cmd = 4'b0001; val_Rm = 32'h8000_0000; shift_operand = 12'h240; dest_in = 4'hA;
    sb.push_back(mk(32'hF800_0000, 32'h8000_0000, 4'hA, 3'b100, 4'b1010));
    step_pop("mov_asr");

    // ORR with Rm ROR #1
    s_in = 0; exe_cmd = 4'b0111; val_Rn = 32'hF; val_Rm = 32'd1; shift_operand = 12'h0E0; dest_in = 4'hB;
    sb.push_back(mk(32'h8000_000F, 32'd1, 4'hB, 3'b100, 4'b1010));
    step_pop("orr_ror");

    // ADD carry out, then ADC using it
    s_in = 1; exe_cmd = 4'b0010; imm = 1; val_Rn = 32'hFFFF_FFFF; val_Rm = 32'd0; shift_operand = 12'h001; dest_in = 4'hC;
    sb.push_back(mk(32'd0, 32'd0, 4'hC, 3'b100, 4'b0110));
    step_pop("add_carry");
    exe_cmd = 4'b0011; val_Rn = 32'h10; shift_operand = 12'h020; dest_in = 4'hD;
    sb.push_back(mk(32'h31, 32'd0, 4'hD, 3'b100, 4'b0000));
    step_pop("adc_c1");

    // SBC with C=0 subtracts one more
    exe_cmd = 4'b0101; val_Rn = 32'd10; shift_operand = 12'h003; dest_in = 4'hE;
    sb.push_back(mk(32'd6, 32'd0, 4'hE, 3'b100, 4'b0010));
    step_pop("sbc_c0");

    // MVN of immediate 0
    s_in = 0; exe_cmd = 4'b1001; shift_operand = 12'h000; dest_in = 4'hF;
    sb.push_back(mk(32'hFFFF_FFFF, 32'd0, 4'hF, 3'b100, 4'b0010));
    step_pop("mvn");

    // AND with Rm LSR #4, then an undefined code acting as MOV
    imm = 0; exe_cmd = 4'b0110; val_Rn = 32'hFFFF_FFFF; val_Rm = 32'hF0; shift_operand = 12'h220; dest_in = 4'd1;
    sb.push_back(mk(32'h0F, 32'hF0, 4'd1, 3'b100, 4'b0010));
    step_pop("and_lsr");
    exe_cmd = 4'b1111; imm = 1; shift_operand = 12'h02A; dest_in = 4'd2;
    sb.push_back(mk(32'h2A, 32'hF0, 4'd2, 3'b100, 4'b0010));
    step_pop("undef_mov");

    // Combinational branch target and hazard copies
    pc_in = 32'h20; signed_imm_24 = 24'hFFFFFE; wb_en_in = 1; dest_in = 4'd5;
    #1;
    chk("branch_back", branch_address, 32'h18);
    chk("haz_wb", {31'd0, wb_en_hazard}, 32'd1);
    chk("haz_dest", {28'd0, dest_hazard}, 32'd5);
    pc_in = 32'hFFFF_FFF0; signed_imm_24 = 24'h000008; wb_en_in = 0; dest_in = 4'd9;
    #1;
    chk("branch_wrap", branch_address, 32'h10);
    chk("haz_wb0", {31'd0, wb_en_hazard}, 32'd0);
    chk("haz_dest9", {28'd0, dest_hazard}, 32'd9);

    // Asynchronous reset in the middle of a freeze
    freeze = 1;
    @(negedge clk);
    rst = 1;
    #1;
    last = '0;
    check_regs("rst_async", last);
    @(posedge clk); #1;
    check_regs("rst_held", last);
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exe_stage_module.md
# exe_stage_module

Execute stage of the 5-stage ARM pipeline, sitting between the ID/EXE register and the memory stage. It holds these pieces:
- operand forwarding muxes;
- the Val2 generator (immediate rotate, register shift, memory offset);
- the ALU and the branch-target adder;
- the NZCV status register;
- the EXE/MEM pipeline register.

The pipeline register's outputs feed the memory stage directly. Its hazard outputs go to the hazard unit.

## Interface
Parameters: none.

Clocking and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- freeze  in  1  memory not ready; hold pipeline register and status register
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from ID/EXE
- s_in  in  1  update status register
- imm  in  1  operand 2 is an immediate
- exe_cmd  in  4  ALU op: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; other codes behave as MOV
- val_Rn, val_Rm  in  32 each  register file operands
- shift_operand  in  12  instruction bits [11:0]
- signed_imm_24  in  24  branch offset
- pc_in  in  32  PC+4 of this instruction
- dest_in  in  4  destination register
- sel_src1, sel_src2  in  2 each  forwarding selects: 00 register file, 01 fwd_mem, 10 fwd_wb, 11 register file
- fwd_mem, fwd_wb  in  32 each  forwarded ALU result (EXE/MEM) and WB value
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered control bits
- alu_res_out, val_Rm_out  out  32 each  registered ALU result and store data
- dest_out  out  4  registered destination
- branch_address  out  32  combinational branch target
- status_out  out  4  registered NZCV, with N at bit 3
- wb_en_hazard, dest_hazard  out  1 / 4  combinational copies of wb_en_in and dest_in

## Operation
Operand forwarding:
- op1 is val_Rn muxed by sel_src1.
- rm is val_Rm muxed by sel_src2. It is used both for the shifter and as store data.

Val2 selection:
- If mem_r_en_in or mem_w_en_in is set: val2 = zero-extended shift_operand[11:0].
- Else if imm is set: val2 = {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
- Else: rm shifted by shift_operand[11:7] with type shift_operand[6:5]:
  - 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - A shift amount of 0 passes rm unchanged.

ALU:
- Add/subtract work on 33 bits. C is bit 32 for adds and NOT borrow for subtracts.
- ADC adds C from status_out. SBC computes op1 - val2 - ~C.
- Memory ops force ADD regardless of exe_cmd.
- V is set for adds on (op1[31]==val2[31]) && (res[31]!=op1[31]). For subtracts it is set on (op1[31]!=val2[31]) && (res[31]!=op1[31]).
- For logic, MOV and MVN, V is 0 and C keeps the current status C.

Branch target: branch_address = pc_in + (sign-extended signed_imm_24 << 2). It wraps modulo 2^32.

Status register:
- Loads {N,Z,C,V} at a clock edge when s_in=1 and freeze=0.
- N = res[31]; Z = (res==0).

EXE/MEM register: loads all registered outputs on every edge with freeze=0. val_Rm_out takes the forwarded rm value.

## Timing
- Latency: one cycle from inputs to the registered outputs.
- branch_address, wb_en_hazard and dest_hazard are combinational, with zero latency.
- Reset clears every registered output and status_out to 0 immediately, without waiting for a clock edge. This includes reset asserted mid-freeze.
- While freeze=1, all registered outputs and status_out hold their values, even if s_in=1.
- When freeze deasserts, the inputs present at the next edge are captured. The ID/EXE register upstream is frozen too, so the held instruction is the one captured.
- An ADC/SBC that follows an S-instruction in the next cycle sees the status already updated at the edge between them.
- The status register updates on the same edge that the instruction's result enters EXE/MEM.
- Flush is not handled here: upstream zeroes the control bits.

## Test plan
- Reset: assert rst mid-cycle with no clock edge -> all outputs read 0 immediately.
- Add with flags: ADD with s_in=1, val_Rn=0x7FFFFFFF, register operand val_Rm=1 with LSL #0 -> alu_res_out=0x80000000 and status_out=1001 after one edge.
- Subtract with borrow: SUB with val_Rn=5, immediate 0x05 rotated by 0 -> result 0, NZCV=0110. A following SBC with 10 - 3 -> 7.
- Immediate rotate: imm=1, shift_operand=0x4FF -> val2=0xFF000000. MOV gives alu_res_out=0xFF000000.
- Forwarding and store: mem_w_en_in=1, sel_src1=01 with fwd_mem=0x100, shift_operand=0x004, sel_src2=10 with fwd_wb=0xABCD -> alu_res_out=0x104, val_Rm_out=0xABCD, mem_w_en_out=1.
- Freeze: hold freeze=1 for 3 cycles while changing inputs and setting s_in=1 -> registered outputs and status are unchanged. Release -> the new values appear after one edge.
- Branch: pc_in=0x20, signed_imm_24=0xFFFFFE -> branch_address=0x18 combinationally.
